// File: rtl/game_pkg.sv
// Shared types and constants for the Cat vs Dog turn scheduler.
package game_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CHARGE,
        ST_THROW,
        ST_RELEASE,
        ST_OVER
    } state_t;

    localparam logic [6:0] WIND_CALM = 7'd50;
    localparam logic [6:0] WIND_MAX  = 7'd100;
    localparam logic [9:0] FORCE_MAX = 10'd1023;
    localparam logic [6:0] LFSR_SEED = 7'h5A;

    // Fold a raw 7-bit LFSR value (1..127) into the wind range 1..100.
    function automatic logic [6:0] wind_fold(input logic [6:0] raw);
        return (raw <= WIND_MAX) ? raw : raw - 7'd27;
    endfunction

endpackage

// File: rtl/wind_lfsr.sv
// Free-running 7-bit LFSR (x^7 + x^6 + 1) producing the next turn's wind.
module wind_lfsr
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] wind_next
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    // Shift left, feedback from the two taps of the primitive polynomial.
    always_comb begin
        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    // Advance every cycle; a nonzero seed keeps it out of the all-zero lock-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            lfsr_q <= lfsr_d;
        end
    end

    assign wind_next = wind_fold(lfsr_q);

endmodule

// File: rtl/turn_ctl.sv
// Turn scheduler: charges throw force, runs alternating throws, tracks HP and winner.
module turn_ctl
    import game_pkg::*;
#(
    parameter int unsigned FORCE_TICK    = 650000,
    parameter int unsigned FORCE_STEP    = 8,
    parameter int unsigned HP_INIT       = 100,
    parameter int unsigned DAMAGE        = 20,
    parameter int unsigned THROW_TIMEOUT = 390000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fire,
    input  logic       hit_cat,
    input  logic       hit_dog,
    input  logic       throw_done_cat,
    input  logic       throw_done_dog,
    output logic       enable_cat,
    output logic       enable_dog,
    output logic [9:0] throw_force,
    output logic [6:0] wind_force,
    output logic [7:0] cat_hp,
    output logic [7:0] dog_hp,
    output logic       turn_dog,
    output logic       charging,
    output logic       game_over,
    output logic       winner_dog
);

    localparam int TICK_W = (FORCE_TICK > 1) ? $clog2(FORCE_TICK) : 1;
    localparam int TMO_W  = (THROW_TIMEOUT > 1) ? $clog2(THROW_TIMEOUT) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FORCE_TICK - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(THROW_TIMEOUT - 1);
    localparam logic [10:0]       STEP      = 11'(FORCE_STEP);
    localparam logic [7:0]        HP_FULL   = 8'(HP_INIT);
    localparam logic [7:0]        DMG       = 8'(DAMAGE);

    state_t              state_q, state_d;
    logic                turn_dog_q, turn_dog_d;
    logic [9:0]          force_q, force_d;
    logic [6:0]          wind_q, wind_d;
    logic [7:0]          cat_hp_q, cat_hp_d;
    logic [7:0]          dog_hp_q, dog_hp_d;
    logic                winner_q, winner_d;
    logic                hit_taken_q, hit_taken_d;
    logic                timed_out_q, timed_out_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                fire_d_q;

    logic       fire_rise;
    logic       active_hit;
    logic       active_done;
    logic [10:0] force_sum;
    logic [9:0]  force_sat;
    logic [6:0]  wind_next;

    wind_lfsr u_wind_lfsr (
        .clk       (clk),
        .rst       (rst),
        .wind_next (wind_next)
    );

    function automatic logic [7:0] hp_after_hit(input logic [7:0] hp);
        return (hp >= DMG) ? hp - DMG : 8'd0;
    endfunction

    assign fire_rise   = fire & ~fire_d_q;
    assign active_hit  = turn_dog_q ? hit_dog : hit_cat;
    assign active_done = turn_dog_q ? throw_done_dog : throw_done_cat;
    assign force_sum   = {1'b0, force_q} + STEP;
    assign force_sat   = (force_sum > {1'b0, FORCE_MAX}) ? FORCE_MAX : force_sum[9:0];

    // Next-state logic for the turn FSM and everything it owns.
    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path infers a latch.
        state_d     = state_q;
        turn_dog_d  = turn_dog_q;
        force_d     = force_q;
        wind_d      = wind_q;
        cat_hp_d    = cat_hp_q;
        dog_hp_d    = dog_hp_q;
        winner_d    = winner_q;
        hit_taken_d = hit_taken_q;
        timed_out_d = timed_out_q;
        tick_d      = tick_q;
        tmo_d       = tmo_q;

        unique case (state_q)
            ST_WAIT: begin
                if (fire_rise) begin
                    state_d = ST_CHARGE;
                    force_d = '0;
                    tick_d  = '0;
                end
            end
            ST_CHARGE: begin
                if (!fire) begin
                    state_d     = ST_THROW;
                    tmo_d       = '0;
                    timed_out_d = 1'b0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    force_d = force_sat;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_THROW: begin
                // One accepted hit per throw, only from the side that is throwing.
                if (active_hit && !hit_taken_q) begin
                    hit_taken_d = 1'b1;
                    if (turn_dog_q) cat_hp_d = hp_after_hit(cat_hp_q);
                    else            dog_hp_d = hp_after_hit(dog_hp_q);
                end
                if (active_done) begin
                    state_d = ST_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = ST_RELEASE;
                    timed_out_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                // A timed-out controller may never drop done, so do not wait on it.
                if (timed_out_q || !active_done) begin
                    hit_taken_d = 1'b0;
                    if (cat_hp_q == 8'd0 || dog_hp_q == 8'd0) begin
                        state_d  = ST_OVER;
                        winner_d = (cat_hp_q == 8'd0);
                    end else begin
                        state_d    = ST_WAIT;
                        turn_dog_d = ~turn_dog_q;
                        wind_d     = wind_next;
                    end
                end
            end
            ST_OVER: begin
                if (fire_rise) begin
                    state_d    = ST_WAIT;
                    cat_hp_d   = HP_FULL;
                    dog_hp_d   = HP_FULL;
                    turn_dog_d = 1'b0;
                    force_d    = '0;
                    wind_d     = WIND_CALM;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            turn_dog_q  <= 1'b0;
            force_q     <= '0;
            wind_q      <= WIND_CALM;
            cat_hp_q    <= HP_FULL;
            dog_hp_q    <= HP_FULL;
            winner_q    <= 1'b0;
            hit_taken_q <= 1'b0;
            timed_out_q <= 1'b0;
            tick_q      <= '0;
            tmo_q       <= '0;
            fire_d_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_dog_q  <= turn_dog_d;
            force_q     <= force_d;
            wind_q      <= wind_d;
            cat_hp_q    <= cat_hp_d;
            dog_hp_q    <= dog_hp_d;
            winner_q    <= winner_d;
            hit_taken_q <= hit_taken_d;
            timed_out_q <= timed_out_d;
            tick_q      <= tick_d;
            tmo_q       <= tmo_d;
            fire_d_q    <= fire;
        end
    end

    assign enable_cat  = (state_q == ST_THROW) && !turn_dog_q;
    assign enable_dog  = (state_q == ST_THROW) &&  turn_dog_q;
    assign throw_force = force_q;
    assign wind_force  = wind_q;
    assign cat_hp      = cat_hp_q;
    assign dog_hp      = dog_hp_q;
    assign turn_dog    = turn_dog_q;
    assign charging    = (state_q == ST_CHARGE);
    assign game_over   = (state_q == ST_OVER);
    assign winner_dog  = winner_q;

endmodule

// File: tb/tb_turn_ctl.sv
// Self-checking bench for turn_ctl with a game-level reference model.
module tb_turn_ctl;

    localparam int FT  = 4;
    localparam int FS  = 8;
    localparam int HPI = 100;
    localparam int DMG = 20;
    localparam int TO  = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fire = 1'b0, hit_cat = 1'b0, hit_dog = 1'b0;
    logic done_cat = 1'b0, done_dog = 1'b0;
    logic       enable_cat, enable_dog, turn_dog, charging, game_over, winner_dog;
    logic [9:0] throw_force;
    logic [6:0] wind_force;
    logic [7:0] cat_hp, dog_hp;

    turn_ctl #(
        .FORCE_TICK(FT), .FORCE_STEP(FS), .HP_INIT(HPI), .DAMAGE(DMG), .THROW_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .fire(fire), .hit_cat(hit_cat), .hit_dog(hit_dog),
        .throw_done_cat(done_cat), .throw_done_dog(done_dog),
        .enable_cat(enable_cat), .enable_dog(enable_dog), .throw_force(throw_force),
        .wind_force(wind_force), .cat_hp(cat_hp), .dog_hp(dog_hp), .turn_dog(turn_dog),
        .charging(charging), .game_over(game_over), .winner_dog(winner_dog)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: phases of a turn, HP arithmetic, force from held time.
    typedef enum {P_IDLE, P_CHARGE, P_FLIGHT, P_SETTLE, P_DONE} phase_e;
    phase_e     ph;
    int         m_held, m_flight, m_cat, m_dog, m_force, m_wind;
    bit         m_turn, m_hit, m_tmo, m_win, m_fprev;
    logic [6:0] m_lfsr;

    function automatic int fold(input logic [6:0] v);
        return (v > 7'd100) ? int'(v) - 27 : int'(v);
    endfunction

    task automatic m_reset();
        ph = P_IDLE; m_held = 0; m_flight = 0; m_cat = HPI; m_dog = HPI;
        m_force = 0; m_wind = 50; m_turn = 0; m_hit = 0; m_tmo = 0; m_win = 0;
        m_fprev = 0; m_lfsr = 7'h5A;
    endtask

    task automatic m_step();
        bit rise, my_hit, my_done;
        rise    = fire && !m_fprev;
        my_hit  = m_turn ? hit_dog : hit_cat;
        my_done = m_turn ? done_dog : done_cat;
        case (ph)
            P_IDLE: if (rise) begin ph = P_CHARGE; m_held = 0; m_force = 0; end
            P_CHARGE: begin
                if (!fire) begin ph = P_FLIGHT; m_flight = 0; m_hit = 0; end
                else begin
                    m_held++;
                    m_force = FS * (m_held / FT);
                    if (m_force > 1023) m_force = 1023;
                end
            end
            P_FLIGHT: begin
                m_flight++;
                if (my_hit && !m_hit) begin
                    m_hit = 1;
                    if (m_turn) begin m_cat = m_cat - DMG; if (m_cat < 0) m_cat = 0; end
                    else        begin m_dog = m_dog - DMG; if (m_dog < 0) m_dog = 0; end
                end
                if (my_done)            begin ph = P_SETTLE; m_tmo = 0; end
                else if (m_flight == TO) begin ph = P_SETTLE; m_tmo = 1; end
            end
            P_SETTLE: if (m_tmo || !my_done) begin
                if (m_cat == 0 || m_dog == 0) begin ph = P_DONE; m_win = (m_cat == 0); end
                else begin ph = P_IDLE; m_turn = !m_turn; m_wind = fold(m_lfsr); end
            end
            P_DONE: if (rise) begin
                ph = P_IDLE; m_cat = HPI; m_dog = HPI; m_turn = 0; m_force = 0; m_wind = 50;
            end
            default: ph = P_IDLE;
        endcase
        m_fprev = fire;
        m_lfsr  = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    // Compare every output against the model on each falling edge.
    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("enable_cat",  32'(enable_cat),  32'(ph == P_FLIGHT && !m_turn));
            check("enable_dog",  32'(enable_dog),  32'(ph == P_FLIGHT && m_turn));
            check("throw_force", 32'(throw_force), 32'(m_force));
            check("wind_force",  32'(wind_force),  32'(m_wind));
            check("cat_hp",      32'(cat_hp),      32'(m_cat));
            check("dog_hp",      32'(dog_hp),      32'(m_dog));
            check("turn_dog",    32'(turn_dog),    32'(m_turn));
            check("charging",    32'(charging),    32'(ph == P_CHARGE));
            check("game_over",   32'(game_over),   32'(ph == P_DONE));
            if (ph == P_DONE) check("winner_dog", 32'(winner_dog), 32'(m_win));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Rise fire, keep it high for `hold` charge cycles, release; returns in the throw.
    task automatic start_throw(input int hold);
        fire = 1'b1;
        repeat (hold + 1) tick();
        fire = 1'b0;
        tick();
    endtask

    task automatic pulse(input bit c, input bit d);
        hit_cat = c; hit_dog = d;
        tick();
        hit_cat = 1'b0; hit_dog = 1'b0;
        tick();
    endtask

    // Active side signals done for two cycles, optionally with a hit in the first.
    task automatic end_throw(input bit with_hit);
        bit dog;
        dog = m_turn;
        if (with_hit) begin if (dog) hit_dog = 1'b1; else hit_cat = 1'b1; end
        if (dog) done_dog = 1'b1; else done_cat = 1'b1;
        tick();
        hit_cat = 1'b0; hit_dog = 1'b0;
        tick();
        done_cat = 1'b0; done_dog = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int cnt;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cmp_on = 1;

        check("rst enable_cat", 32'(enable_cat), 0);
        check("rst enable_dog", 32'(enable_dog), 0);
        check("rst force",      32'(throw_force), 0);
        check("rst wind",       32'(wind_force), 50);
        check("rst cat_hp",     32'(cat_hp), 100);
        check("rst dog_hp",     32'(dog_hp), 100);
        check("rst game_over",  32'(game_over), 0);

        // Cat throw: 40 held cycles -> 10 ticks of 8; two cat hits count once, dog hit ignored.
        start_throw(40);
        check("t1 force",      32'(throw_force), 80);
        check("t1 enable_cat", 32'(enable_cat), 1);
        check("t1 enable_dog", 32'(enable_dog), 0);
        pulse(1, 0); pulse(0, 1); pulse(1, 0);
        end_throw(0);
        check("t1 dog_hp",   32'(dog_hp), 80);
        check("t1 cat_hp",   32'(cat_hp), 100);
        check("t1 turn_dog", 32'(turn_dog), 1);
        check("t1 wind range", 32'(wind_force >= 7'd1 && wind_force <= 7'd100), 1);

        // Hits while idle are ignored.
        pulse(1, 1);
        check("idle hit dog_hp", 32'(dog_hp), 80);
        check("idle hit cat_hp", 32'(cat_hp), 100);

        // Dog miss with an inactive-side hit, fire re-pressed and held into WAIT.
        start_throw(6);
        pulse(1, 0);
        fire = 1'b1;
        tick();
        end_throw(0);
        repeat (3) tick();
        check("held fire no charge", 32'(charging), 0);
        fire = 1'b0;
        tick();
        check("t2 dog_hp",   32'(dog_hp), 80);
        check("t2 turn_dog", 32'(turn_dog), 0);

        // Cat throw with no done: enable must last exactly TO cycles, turn passes to dog.
        start_throw(5);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (enable_cat) cnt++;
            tick();
        end
        check("timeout enable cycles", 32'(cnt), 20);
        check("timeout turn_dog", 32'(turn_dog), 1);

        // Dog throw held 700 ticks: force clips at 1023; dog hit lands on cat.
        start_throw(2800);
        check("sat force", 32'(throw_force), 1023);
        pulse(0, 1);
        end_throw(0);
        check("t4 cat_hp", 32'(cat_hp), 80);

        // Remaining cat hits interleaved with dog misses; last hit coincides with done.
        for (int k = 0; k < 7; k++) begin
            start_throw(3 + k);
            if (k == 6) end_throw(1);
            else if (k % 2 == 0) begin pulse(1, 0); end_throw(0); end
            else end_throw(0);
        end
        check("over dog_hp",     32'(dog_hp), 0);
        check("over game_over",  32'(game_over), 1);
        check("over winner_dog", 32'(winner_dog), 0);

        // A fire rise restarts the game.
        fire = 1'b1;
        tick();
        check("restart cat_hp",   32'(cat_hp), 100);
        check("restart dog_hp",   32'(dog_hp), 100);
        check("restart turn_dog", 32'(turn_dog), 0);
        check("restart wind",     32'(wind_force), 50);
        fire = 1'b0;
        tick();

        // Asynchronous reset in the middle of a cat throw.
        start_throw(4);
        pulse(1, 0);
        check("pre-rst dog_hp", 32'(dog_hp), 80);
        #2 rst = 1'b1;
        #1;
        check("rst mid enable_cat", 32'(enable_cat), 0);
        check("rst mid dog_hp",     32'(dog_hp), 100);
        check("rst mid cat_hp",     32'(cat_hp), 100);
        check("rst mid wind",       32'(wind_force), 50);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/turn_ctl.md
# turn_ctl

Game turn scheduler for Cat vs Dog. It alternates throws between the cat and dog trajectory controllers and captures throw force from the fire button. It generates a fresh wind value per turn, keeps both players' hit points and declares the winner. It sits between the input/debounce logic and the two throw controllers, and feeds the HUD/draw blocks.

## Interface
- `FORCE_TICK`, default 650000: clk cycles per force increment (10 ms at 65 MHz).
- `FORCE_STEP`, default 8: force increment per tick.
- `HP_INIT`, default 100: starting hit points per player.
- `DAMAGE`, default 20: HP removed per hit.
- `THROW_TIMEOUT`, default 390000000: max cycles in a throw (6 s at 65 MHz).
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset. This is the single clock domain; polarity and asynchronous behaviour are fixed.
- `fire`  in  1: debounced fire button level.
- `hit_cat`  in  1: one-cycle pulse, the cat projectile hit the dog.
- `hit_dog`  in  1: one-cycle pulse, the dog projectile hit the cat.
- `throw_done_cat`  in  1: cat controller reached its end state.
- `throw_done_dog`  in  1: dog controller reached its end state.
- `enable_cat`  out  1: level, starts and holds the cat throw.
- `enable_dog`  out  1: level, starts and holds the dog throw.
- `throw_force`  out  10: force for the active throw.
- `wind_force`  out  7: wind for the current turn, range 1..100; 50 means calm.
- `cat_hp`  out  8: cat hit points.
- `dog_hp`  out  8: dog hit points.
- `turn_dog`  out  1: 0 means cat's turn, 1 means dog's turn.
- `charging`  out  1: high in ST_CHARGE.
- `game_over`  out  1: high in ST_OVER.
- `winner_dog`  out  1: valid when `game_over` is high; 1 means the dog won.

## Operation
- Reset values:
  - state ST_WAIT, `turn_dog`=0.
  - `throw_force`=0, `wind_force`=50.
  - `cat_hp`=`dog_hp`=HP_INIT.
  - All enables, `charging`, `game_over` and `winner_dog` are 0.
  - LFSR is 7'h5A, `fire_d`=0.
- `fire_d` registers `fire` every cycle. A rise is `fire && !fire_d`.
- ST_WAIT: enables are low. On a rise, go to ST_CHARGE, clear `throw_force` to 0 and clear the tick counter.
- ST_CHARGE:
  - Each time the tick counter reaches FORCE_TICK-1, add FORCE_STEP to `throw_force`, saturating at 1023, and reset the counter.
  - On `!fire`, go to ST_THROW. The force is frozen from this point.
- ST_THROW:
  - Assert `enable_cat` if `turn_dog`=0, otherwise assert `enable_dog`. Never assert both.
  - Count the timeout.
  - Only the active side's hit pulse is accepted, at most once per throw, tracked by a `hit_taken` flag. An accepted hit subtracts DAMAGE from the opponent's HP, saturating at 0.
  - Go to ST_RELEASE on the active `throw_done_*`, or when the timeout reaches THROW_TIMEOUT-1.
- ST_RELEASE:
  - Drop the enable.
  - Wait until the active `throw_done_*` is low; on timeout exit, skip the wait.
  - If either HP is 0, go to ST_OVER and set `winner_dog` = (`cat_hp`==0).
  - Otherwise toggle `turn_dog`, load the new wind, clear `hit_taken` and go to ST_WAIT.
- ST_OVER: on a rise, reload both HPs to HP_INIT, set `turn_dog`=0, `throw_force`=0, `wind_force`=50, and go to ST_WAIT.
- Wind generation:
  - The LFSR is 7-bit, x^7+x^6+1, and free-runs every cycle. It never reaches 0.
  - New wind is `lfsr` if `lfsr`<=100, else `lfsr`-27. The result is always in 1..100.

## Timing
- `enable_*` rises on the cycle after the `fire` release is sampled, and stays high while in ST_THROW.
- `throw_done_*` seen in cycle N: enable is low in N+1.
- HP updates one cycle after the hit pulse.
- A hit pulse and `throw_done` in the same cycle: the hit is counted, then the state goes to ST_RELEASE.
- Hit pulses outside ST_THROW, or from the inactive side, are ignored.
- A `fire` held through ST_RELEASE into ST_WAIT does not start a charge; a fresh rise is required.
- Asynchronous `rst` mid-throw: all outputs go to their reset values immediately, and enables go low without waiting for `throw_done`.

## Structure
- `game_pkg` holds:
  - `state_t` enum {ST_WAIT, ST_CHARGE, ST_THROW, ST_RELEASE, ST_OVER}.
  - WIND_CALM=50, WIND_MAX=100.
  - FORCE_MAX=1023.
- Sub-module `wind_lfsr`: LFSR plus the range fold. Inputs `clk`, `rst`. Output `wind_next[6:0]`, combinational from the LFSR register.

## Test plan
- Test build with FORCE_TICK=4. Rise `fire`, hold 40 cycles, release. Expect `throw_force`=80 (10 ticks × 8), `enable_cat` high the next cycle, `enable_dog` low.
- Hold `fire` for 700 ticks. Expect `throw_force` to saturate at 1023 (step 8 overshoot clipped) with no wrap.
- During a cat throw, send `hit_cat` twice and `hit_dog` once, then `throw_done_cat`. Expect `dog_hp`=80, `cat_hp`=100, `turn_dog`=1, and a new `wind_force` in 1..100.
- Five cat hits interleaved with dog misses. Expect `dog_hp`=0 after the fifth, then `game_over`=1 and `winner_dog`=0. The next `fire` rise restores HP 100/100 and `turn_dog`=0.
- Test build with THROW_TIMEOUT=20 and no `throw_done`. Expect the enable to drop after 20 cycles and the turn to pass to the dog.
- Assert `rst` during ST_THROW. Expect the enable to drop in the same cycle, HP back at 100/100, and `wind_force`=50.
